// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit that sits beside the exe stage.
// It uses a shift-add multiplier and a restoring divider. Each takes one bit per
// cycle for DATA_WIDTH cycles. It then spends one FIX cycle on sign correction
// and one DONE cycle that returns the result.
//
// Handshake: exe raises start_i with the decoded op and operands. While the unit is
// idle, stall_o follows start_i in the same cycle so exe holds the instruction. The
// unit accepts the request on that edge and keeps stall_o high through CALC and FIX.
// In DONE, stall_o is low and done_o/reg_we_o pulse for one cycle with result_o and
// reg_waddr_o. start_i is never accepted outside IDLE. flush_i drops an in-flight op
// and masks a DONE pulse that is showing in the same cycle.
module muldiv_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [2:0]             op_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   stall_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                 state_q;
  logic [2:0]             op_q;
  logic [RADDR_WIDTH-1:0] rd_q;
  logic [CW-1:0]          cnt_q;
  logic [W-1:0]           b_q;      // multiplicand or divisor magnitude
  logic [2*W-1:0]         acc_q;    // product, or {unused, dividend/quotient}
  logic [W-1:0]           rem_q;    // partial remainder (always < divisor)
  logic                   neg_q;    // product / quotient needs negation
  logic                   rneg_q;   // remainder needs negation
  logic                   done_q;
  logic [W-1:0]           result_q;

  // Launch-time decode: operand signs, magnitudes and the special cases
  // that bypass the iteration.
  logic         s1, s2, is_div, div0, ovf;
  logic [W-1:0] a_abs, b_abs, special;
  always_comb begin
    s1      = op1_i[W-1] & ((op_i == OP_MULH) | (op_i == OP_MULHSU) |
                            (op_i == OP_DIV)  | (op_i == OP_REM));
    s2      = op2_i[W-1] & ((op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM));
    a_abs   = s1 ? -op1_i : op1_i;
    b_abs   = s2 ? -op2_i : op2_i;
    is_div  = op_i[2];
    div0    = is_div & (op2_i == '0);
    ovf     = ((op_i == OP_DIV) | (op_i == OP_REM)) &
              (op1_i == {1'b1, {(W-1){1'b0}}}) & (op2_i == '1);
    special = '1;
    if (div0)     special = op_i[1] ? op1_i : '1;
    else if (ovf) special = op_i[1] ? '0 : op1_i;
  end

  // One iteration step of each datapath. The divider's trial remainder is
  // W+1 bits wide: the shifted partial remainder can exceed W bits.
  logic [W:0]     mul_sum, div_shift, div_sub;
  logic [2*W-1:0] mul_next;
  logic [W-1:0]   rem_next, quot_next;
  logic           div_ok;
  logic           unused_sub_msb;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {rem_q, acc_q[W-1]};
    div_ok    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift - {1'b0, b_q};
    rem_next  = div_ok ? div_sub[W-1:0] : div_shift[W-1:0];
    quot_next = {acc_q[W-2:0], div_ok};
    unused_sub_msb = div_sub[W];
  end

  // Sign correction and result selection used in FIX.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, fix_result;
  always_comb begin
    prod_fix = neg_q  ? -acc_q : acc_q;
    quot_fix = neg_q  ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = rneg_q ? -rem_q : rem_q;
    case (op_q)
      3'b000:                 fix_result = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_result = quot_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  // Sequencer FSM together with the datapath registers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q   <= op_i;
            rd_q   <= reg_waddr_i;
            cnt_q  <= '0;
            rem_q  <= '0;
            b_q    <= b_abs;
            acc_q  <= {{W{1'b0}}, a_abs};
            neg_q  <= s1 ^ s2;
            rneg_q <= s1;
            if (div0 || ovf) begin
              result_q <= special;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            if (op_q[2]) begin
              acc_q <= {acc_q[2*W-1:W], quot_next};
              rem_q <= rem_next;
            end else begin
              acc_q <= mul_next;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(W-1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_result;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A flush landing in the DONE cycle must cancel the write-back, so the
  // registered pulse is masked by flush_i.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    stall_o     = ((state_q == S_IDLE) & start_i) | (state_q == S_CALC) | (state_q == S_FIX);
    done_o      = done_q & ~flush_i;
    reg_we_o    = done_q & ~flush_i;
    result_o    = result_q;
    reg_waddr_o = rd_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: the expected results and latencies are computed by hand.
module tb_muldiv_seq;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        busy_o, stall_o, done_o, reg_we_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  muldiv_seq #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .op1_i(op1_i), .op2_i(op2_i), .reg_waddr_i(reg_waddr_i), .flush_i(flush_i),
    .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .result_o(result_o),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Launches one op and checks its latency, result, write-enable and rd.
  // With poke set, start_i is re-raised with a different op from CALC cycle 5
  // and held until after DONE, so it must be ignored in CALC, FIX and DONE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat, input bit poke);
    int cyc;
    logic [31:0] e;
    @(negedge clk_i);
    op_i = op; op1_i = a; op2_i = b; reg_waddr_i = rd; start_i = 1'b1;
    exp_q.push_back(exp);
    #1 check({tag, "_stall_req"}, stall_o, 1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 60) begin
      if (poke && cyc == 5) begin
        start_i = 1'b1; op_i = 3'b101; op2_i = 32'h0; reg_waddr_i = 5'd9;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    e = exp_q.pop_front();
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_res"}, result_o, e);
    check({tag, "_we"}, reg_we_o, 1);
    check({tag, "_rd"}, reg_waddr_o, rd);
    check({tag, "_stall_done"}, stall_o, 0);
    @(posedge clk_i); #1;
    check({tag, "_pulse_end"}, done_o, 0);
    check({tag, "_idle"}, busy_o, 0);
    if (poke) begin
      check({tag, "_stall_idle"}, stall_o, 1);
      start_i = 1'b0;
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; op1_i = '0; op2_i = '0; reg_waddr_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    check("rst_we", reg_we_o, 0);
    check("rst_res", result_o, 0);
    check("rst_rd", reg_waddr_o, 0);
    @(negedge clk_i); rst_i = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34, 1'b0);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34, 1'b0);
    run_op("mulhu",  3'b011, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 34, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34, 1'b0);
    run_op("mulhu2", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 34, 1'b0);
    run_op("mulh2",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000000, 34, 1'b0);
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1,  1'b0);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1,  1'b0);
    run_op("divu0",  3'b101, 32'd123,      32'd0,        5'd14, 32'hFFFFFFFF, 1,  1'b0);
    run_op("remu0",  3'b111, 32'd123,      32'd0,        5'd15, 32'd123,      1,  1'b0);
    run_op("div0",   3'b100, 32'd123,      32'd0,        5'd16, 32'hFFFFFFFF, 1,  1'b0);
    run_op("rem_n",  3'b110, 32'hFFFFFFF9, 32'd2,        5'd17, 32'hFFFFFFFF, 34, 1'b0);
    run_op("div_n",  3'b100, 32'hFFFFFFF9, 32'd2,        5'd18, 32'hFFFFFFFD, 34, 1'b0);
    run_op("div_d",  3'b100, 32'd7,        32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_d",  3'b110, 32'd7,        32'hFFFFFFFE, 5'd20, 32'd1,        34, 1'b0);
    run_op("divu",   3'b101, 32'd100,      32'd7,        5'd21, 32'd14,       34, 1'b0);
    run_op("remu",   3'b111, 32'd100,      32'd7,        5'd22, 32'd2,        34, 1'b0);

    // flush in CALC cycle 10
    @(negedge clk_i);
    op_i = 3'b000; op1_i = 32'd6; op2_i = 32'd7; reg_waddr_i = 5'd4; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    check("fl_busy_pre", busy_o, 1);
    check("fl_stall_pre", stall_o, 1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("fl_busy", busy_o, 0);
    check("fl_stall", stall_o, 0);
    check("fl_done", done_o, 0);
    watch_no_done("fl_no_done", 40);
    run_op("post_fl", 3'b000, 32'd6, 32'd7, 5'd4, 32'd42, 34, 1'b0);

    // flush during the DONE cycle masks the write-back pulse
    @(negedge clk_i);
    op_i = 3'b101; op1_i = 32'd5; op2_i = 32'd0; reg_waddr_i = 5'd3; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("fd_done_pre", done_o, 1);
    flush_i = 1'b1;
    #1;
    check("fd_done", done_o, 0);
    check("fd_we", reg_we_o, 0);
    @(negedge clk_i); flush_i = 1'b0;
    @(posedge clk_i); #1;
    check("fd_idle", busy_o, 0);

    // start while busy must not disturb the in-flight op
    run_op("poke", 3'b000, 32'd3, 32'd5, 5'd7, 32'd15, 34, 1'b1);

    // asynchronous reset mid-CALC
    @(negedge clk_i);
    op_i = 3'b000; op1_i = 32'd3; op2_i = 32'd3; reg_waddr_i = 5'd12; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("ar_busy", busy_o, 0);
    check("ar_stall", stall_o, 0);
    check("ar_done", done_o, 0);
    check("ar_we", reg_we_o, 0);
    check("ar_res", result_o, 0);
    check("ar_rd", reg_waddr_o, 0);
    @(negedge clk_i); rst_i = 1'b0;
    watch_no_done("ar_no_done", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
